// File: rtl/sobel_line_window_line_ram.sv
// Simple dual-port line store: read-first, registered read, no reset on contents.
// Shaped for block RAM inference; o_rdata holds while i_re is low.
module line_ram #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 10
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [A_WIDTH-1:0] i_waddr,
  input  logic [D_WIDTH-1:0] i_wdata,
  input  logic               i_re,
  input  logic [A_WIDTH-1:0] i_raddr,
  output logic [D_WIDTH-1:0] o_rdata
);

  logic [D_WIDTH-1:0] mem [0:(1<<A_WIDTH)-1];

  // Read-first: a same-address write this cycle is not visible to this read.
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/sobel_line_window.sv
// Raster luma in, three vertically aligned taps (n-2, n-1, n) out for the Sobel core.
// Two line stores form the vertical delay; early rows of a frame are masked to zero.
module sobel_line_window #(
  parameter int Y_DEPTH  = 8,
  parameter int H_ACTIVE = 640,
  parameter int ADDR_W   = 10
) (
  input  logic               i_arst,
  input  logic               i_pclk,
  input  logic               i_sof,
  input  logic               i_valid,
  input  logic [Y_DEPTH-1:0] i_pixel,
  output logic               o_valid,
  output logic [Y_DEPTH-1:0] o_pixel_11,
  output logic [Y_DEPTH-1:0] o_pixel_00,
  output logic [Y_DEPTH-1:0] o_pixel_01,
  output logic               o_sol,
  output logic               o_win_ok
);

  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(H_ACTIVE - 1);

  logic [ADDR_W-1:0]  x_cnt, addr, addr_q;
  logic [1:0]         line_cnt, line_eff, line_q;
  logic               vld_q;
  logic [Y_DEPTH-1:0] lb0_rdata, lb1_rdata;

  // A start-of-frame pixel is treated as x=0 of line 0 in the same cycle.
  assign addr     = i_sof ? '0 : x_cnt;
  assign line_eff = i_sof ? 2'd0 : line_cnt;

  always_ff @(posedge i_pclk or posedge i_arst) begin
    if (i_arst) begin
      x_cnt      <= '0;
      line_cnt   <= '0;
      addr_q     <= '0;
      line_q     <= '0;
      vld_q      <= 1'b0;
      o_pixel_01 <= '0;
      o_sol      <= 1'b0;
      o_win_ok   <= 1'b0;
    end else begin
      vld_q <= i_valid;
      if (i_valid) begin
        addr_q     <= addr;
        line_q     <= line_eff;
        o_pixel_01 <= i_pixel;
        o_sol      <= (addr == '0);
        o_win_ok   <= (line_eff == 2'd2);
        x_cnt      <= (addr == X_LAST) ? '0 : addr + 1'b1;
        line_cnt   <= (addr == X_LAST && line_eff != 2'd2) ? line_eff + 2'd1 : line_eff;
      end
    end
  end

  // lb0 = line n-1 (written with the live pixel), lb1 = line n-2 (fed from lb0 one cycle later).
  line_ram #(.D_WIDTH(Y_DEPTH), .A_WIDTH(ADDR_W)) u_lb0 (
    .i_clk   (i_pclk),
    .i_we    (i_valid),
    .i_waddr (addr),
    .i_wdata (i_pixel),
    .i_re    (i_valid),
    .i_raddr (addr),
    .o_rdata (lb0_rdata)
  );

  line_ram #(.D_WIDTH(Y_DEPTH), .A_WIDTH(ADDR_W)) u_lb1 (
    .i_clk   (i_pclk),
    .i_we    (vld_q),
    .i_waddr (addr_q),
    .i_wdata (lb0_rdata),
    .i_re    (i_valid),
    .i_raddr (addr),
    .o_rdata (lb1_rdata)
  );

  // RAM outputs hold during gaps, and line_q resets to 0 so stale contents never leak.
  assign o_valid    = vld_q;
  assign o_pixel_00 = (line_q != 2'd0) ? lb0_rdata : '0;
  assign o_pixel_11 = line_q[1] ? lb1_rdata : '0;

endmodule

// File: tb/tb_sobel_line_window.sv
// Directed bench for sobel_line_window at H_ACTIVE=4: frame-level reference model
// compared every cycle, plus literal tap values pinned at chosen pixels.
module tb_sobel_line_window;
  localparam int H = 4;
  localparam int YD = 8;

  logic          i_arst, i_pclk, i_sof, i_valid;
  logic [YD-1:0] i_pixel;
  logic          o_valid, o_sol, o_win_ok;
  logic [YD-1:0] o_pixel_11, o_pixel_00, o_pixel_01;

  sobel_line_window #(.Y_DEPTH(YD), .H_ACTIVE(H), .ADDR_W(2)) dut (
    .i_arst(i_arst), .i_pclk(i_pclk), .i_sof(i_sof), .i_valid(i_valid), .i_pixel(i_pixel),
    .o_valid(o_valid), .o_pixel_11(o_pixel_11), .o_pixel_00(o_pixel_00), .o_pixel_01(o_pixel_01),
    .o_sol(o_sol), .o_win_ok(o_win_ok)
  );

  initial i_pclk = 1'b0;
  always #5 i_pclk = ~i_pclk;

  int errors = 0;
  int checks = 0;

  // Reference model: whole-frame image keyed by (line, x), unbounded line number.
  logic [YD-1:0] img [int];
  int            mx, ml;
  logic          exp_v, exp_sol, exp_win;
  logic [YD-1:0] exp_11, exp_00, exp_01;

  logic          chk_en = 1'b0, pin_en = 1'b0;
  logic [YD-1:0] lit_11, lit_00, lit_01;
  logic          lit_sol, lit_win;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge i_pclk) begin
    if (chk_en) begin
      chk("o_valid", int'(o_valid), int'(exp_v));
      chk("o_pixel_11", int'(o_pixel_11), int'(exp_11));
      chk("o_pixel_00", int'(o_pixel_00), int'(exp_00));
      chk("o_pixel_01", int'(o_pixel_01), int'(exp_01));
      chk("o_sol", int'(o_sol), int'(exp_sol));
      chk("o_win_ok", int'(o_win_ok), int'(exp_win));
      if (pin_en) begin
        chk("pin_11", int'(o_pixel_11), int'(lit_11));
        chk("pin_00", int'(o_pixel_00), int'(lit_00));
        chk("pin_01", int'(o_pixel_01), int'(lit_01));
        chk("pin_sol", int'(o_sol), int'(lit_sol));
        chk("pin_win", int'(o_win_ok), int'(lit_win));
      end
    end
  end

  task automatic model_reset();
    mx = 0; ml = 0; img.delete();
    exp_v = 0; exp_sol = 0; exp_win = 0;
    exp_11 = '0; exp_00 = '0; exp_01 = '0;
  endtask

  task automatic step(input logic v, input logic s, input logic [YD-1:0] p);
    int ex, el;
    i_valid = v; i_sof = s; i_pixel = p;
    @(posedge i_pclk);
    exp_v = v;
    if (v) begin
      ex = s ? 0 : mx;
      el = s ? 0 : ml;
      exp_01  = p;
      exp_00  = (el >= 1) ? img[(el-1)*H + ex] : '0;
      exp_11  = (el >= 2) ? img[(el-2)*H + ex] : '0;
      exp_sol = (ex == 0);
      exp_win = (el >= 2);
      img[el*H + ex] = p;
      mx = ex + 1; ml = el;
      if (mx == H) begin mx = 0; ml++; end
    end
    #1;
  endtask

  task automatic pin(input logic [YD-1:0] a, input logic [YD-1:0] b, input logic [YD-1:0] c,
                     input logic s, input logic w);
    lit_11 = a; lit_00 = b; lit_01 = c; lit_sol = s; lit_win = w;
    pin_en = 1'b1;
    @(negedge i_pclk);
    #1 pin_en = 1'b0;
  endtask

  // Three-line ramp 16*line+x; optional invalid cycle (with stray sof) after every pixel.
  task automatic ramp_frame(input bit gaps);
    for (int l = 0; l < 3; l++)
      for (int x = 0; x < H; x++) begin
        step(1'b1, (l == 0 && x == 0), 8'(16*l + x));
        if (l == 1 && x == 3) pin(8'd0, 8'd3, 8'd19, 1'b0, 1'b0);
        if (l == 2 && x == 0) pin(8'd0, 8'd16, 8'd32, 1'b1, 1'b1);
        if (l == 2 && x == 1) pin(8'd1, 8'd17, 8'd33, 1'b0, 1'b1);
        if (gaps) begin
          step(1'b0, 1'b1, 8'hEE);
          if (l == 2 && x == 1) pin(8'd1, 8'd17, 8'd33, 1'b0, 1'b1);
        end
      end
  endtask

  initial begin
    i_arst = 1'b1; i_sof = 1'b0; i_valid = 1'b0; i_pixel = '0;
    model_reset();
    @(posedge i_pclk); #1;
    chk_en = 1'b1;
    @(posedge i_pclk); #1;
    i_arst = 1'b0;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h55);

    ramp_frame(1'b0);
    step(1'b0, 1'b0, 8'h00);
    ramp_frame(1'b1);

    // Restart mid-line: sof on line 5, x=2.
    for (int k = 0; k < 5*H + 2; k++) step(1'b1, (k == 0), 8'(8'h80 + k));
    step(1'b1, 1'b1, 8'hA5);
    pin(8'd0, 8'd0, 8'hA5, 1'b1, 1'b0);
    for (int k = 0; k < 3*H; k++) step(1'b1, 1'b0, 8'(8'h40 + k));

    // Reset during line 3 x=1 of a random frame.
    for (int k = 0; k < 3*H + 2; k++) step(1'b1, (k == 0), 8'($urandom_range(0, 255)));
    i_arst = 1'b1; i_valid = 1'b0;
    model_reset();
    pin(8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    @(posedge i_pclk); #1;
    i_arst = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    ramp_frame(1'b0);
    step(1'b0, 1'b0, 8'h00);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
